// File: rtl/sram_arbiter.sv
// Arbiter owning the video SRAM pins: prioritised video byte reads with req/ack,
// plus a small write FIFO drained with programmable wait-state write cycles.
module sram_arbiter #(
   parameter int unsigned AW      = 17,
   parameter int unsigned DW      = 8,
   parameter int unsigned RD_WAIT = 6,
   parameter int unsigned WR_WAIT = 5,
   parameter int unsigned FDEPTH  = 4,
   parameter int unsigned STARVE  = 4
) (
   input  logic          clk100,
   input  logic          rst,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic [DW-1:0] vid_data,
   input  logic          wr_push,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_full,
   output logic [2:0]    wr_count,
   output logic          wr_drop,
   output logic          s_ce,
   output logic          s_oe,
   output logic          s_we,
   output logic [AW-1:0] o_saddr,
   output logic [DW-1:0] s_dout,
   output logic          s_drive,
   input  logic [DW-1:0] s_din,
   output logic          busy
);

   localparam int unsigned PW   = $clog2(FDEPTH);
   localparam int unsigned MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
   localparam int unsigned CW   = $clog2(MAXW) + 1;
   localparam int unsigned SW   = $clog2(STARVE + 1);

   typedef enum logic [2:0] {IDLE, RD, ACK, WS, WP, WH} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [SW-1:0] starve;

   logic [AW-1:0] fifo_addr [FDEPTH];
   logic [DW-1:0] fifo_data [FDEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [2:0]    count_nxt;

   logic fifo_empty;
   logic grant_vid;
   logic grant_wr;
   logic pop;
   logic push_ok;

   assign fifo_empty = (wr_count == 3'd0);
   assign grant_vid  = (state == IDLE) && vid_req && (fifo_empty || (starve < SW'(STARVE)));
   assign grant_wr   = (state == IDLE) && !grant_vid && !fifo_empty;
   assign pop        = (state == WH);
   // A full FIFO still accepts a push on the edge that retires its head.
   assign push_ok    = wr_push && (!wr_full || pop);

   always_comb begin
      count_nxt = wr_count;
      if (push_ok && !pop)
         count_nxt = wr_count + 3'd1;
      else if (!push_ok && pop)
         count_nxt = wr_count - 3'd1;
   end

   // FIFO storage: no reset needed, occupancy is tracked by the pointers.
   always_ff @(posedge clk100) begin
      if (push_ok) begin
         fifo_addr[wr_ptr] <= wr_addr;
         fifo_data[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk100) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         wr_count <= 3'd0;
         wr_full  <= 1'b0;
         wr_drop  <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= PW'(wr_ptr + 1'b1);
         if (pop)
            rd_ptr <= PW'(rd_ptr + 1'b1);
         wr_count <= count_nxt;
         wr_full  <= (count_nxt == 3'(FDEPTH));
         wr_drop  <= wr_push && !push_ok;
      end
   end

   // Bounds how many reads may overtake a pending write.
   always_ff @(posedge clk100) begin
      if (rst)
         starve <= '0;
      else if (fifo_empty || grant_wr)
         starve <= '0;
      else if (grant_vid && (starve < SW'(STARVE)))
         starve <= starve + SW'(1);
   end

   always_ff @(posedge clk100) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         s_ce     <= 1'b1;
         s_oe     <= 1'b1;
         s_we     <= 1'b1;
         s_drive  <= 1'b0;
         o_saddr  <= '0;
         s_dout   <= '0;
         vid_ack  <= 1'b0;
         vid_data <= '0;
         busy     <= 1'b0;
      end else begin
         vid_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_vid) begin
                  state   <= RD;
                  o_saddr <= vid_addr;
                  s_ce    <= 1'b0;
                  s_oe    <= 1'b0;
                  s_drive <= 1'b0;
                  cnt     <= CW'(RD_WAIT - 1);
                  busy    <= 1'b1;
               end else if (grant_wr) begin
                  state   <= WS;
                  o_saddr <= fifo_addr[rd_ptr];
                  s_dout  <= fifo_data[rd_ptr];
                  s_ce    <= 1'b0;
                  s_we    <= 1'b1;
                  s_drive <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            RD: begin
               if (cnt == '0) begin
                  state    <= ACK;
                  vid_data <= s_din;
                  s_ce     <= 1'b1;
                  s_oe     <= 1'b1;
                  vid_ack  <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ACK: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            WS: begin
               state <= WP;
               s_we  <= 1'b0;
               cnt   <= CW'(WR_WAIT - 1);
            end
            WP: begin
               if (cnt == '0) begin
                  state <= WH;
                  s_we  <= 1'b1;
                  s_ce  <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            WH: begin
               state   <= IDLE;
               s_drive <= 1'b0;
               busy    <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               s_ce    <= 1'b1;
               s_oe    <= 1'b1;
               s_we    <= 1'b1;
               s_drive <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: transaction table against an SRAM model,
// plus hand-written starvation, FIFO-full and mid-cycle reset sequences.
module tb_sram_arbiter;

   localparam int unsigned AW = 17;
   localparam int unsigned DW = 8;

   logic          clk100 = 1'b0;
   logic          rst;
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic          vid_ack;
   logic [DW-1:0] vid_data;
   logic          wr_push;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_full;
   logic [2:0]    wr_count;
   logic          wr_drop;
   logic          s_ce;
   logic          s_oe;
   logic          s_we;
   logic [AW-1:0] o_saddr;
   logic [DW-1:0] s_dout;
   logic          s_drive;
   logic [DW-1:0] s_din;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk100 = ~clk100;

   sram_arbiter #(
      .AW(AW), .DW(DW), .RD_WAIT(6), .WR_WAIT(5), .FDEPTH(4), .STARVE(4)
   ) dut (
      .clk100(clk100), .rst(rst),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
      .wr_push(wr_push), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_full(wr_full), .wr_count(wr_count), .wr_drop(wr_drop),
      .s_ce(s_ce), .s_oe(s_oe), .s_we(s_we), .o_saddr(o_saddr),
      .s_dout(s_dout), .s_drive(s_drive), .s_din(s_din), .busy(busy)
   );

   // SRAM model: cleared and preset on the first edge, then written through the pins.
   logic [7:0] mem [0:131071];
   logic       mem_ready = 1'b0;

   always @(posedge clk100) begin
      if (!mem_ready) begin
         for (int i = 0; i < 131072; i++) mem[i] <= 8'h00;
         mem[17'h12345] <= 8'hA5;
         mem[17'h00000] <= 8'h5A;
         mem_ready      <= 1'b1;
      end else if (!s_ce && !s_we && s_drive) begin
         mem[o_saddr] <= s_dout;
      end
   end

   assign s_din = (!s_ce && !s_oe) ? mem[o_saddr] : 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Bus protocol: OE and WE never low together; pins driven only while OE is high.
   always @(negedge clk100) begin
      if (!rst)
         check("bus_protocol", {30'd0, (!s_oe && !s_we), (s_drive && !s_oe)}, 32'd0);
   end

   task automatic do_read(input logic [16:0] a, output logic [7:0] d, output int lat,
                          output int oe_n);
      lat  = -1;
      oe_n = 0;
      d    = 8'h00;
      @(negedge clk100);
      vid_req  = 1'b1;
      vid_addr = a;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk100); #1;
         if (!s_oe && !s_ce) oe_n++;
         if (vid_ack) begin
            lat = i;
            d   = vid_data;
            break;
         end
      end
      vid_req = 1'b0;
   endtask

   task automatic do_write(input logic [16:0] a, input logic [7:0] dat, output int cnt1,
                           output int drv_n, output int we_n, output int done);
      @(negedge clk100);
      wr_push = 1'b1;
      wr_addr = a;
      wr_data = dat;
      @(posedge clk100); #1;
      cnt1    = int'(wr_count);
      wr_push = 1'b0;
      done    = 0;
      drv_n   = 0;
      we_n    = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk100); #1;
         if (s_drive) drv_n++;
         if (!s_we) we_n++;
         if (wr_count == 3'd0 && !busy) begin
            done = 1;
            break;
         end
      end
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      int ok;
      ok = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge clk100); #1;
         if (!busy && wr_count == 3'd0) begin
            ok = 1;
            break;
         end
      end
      check(name, ok, 1);
   endtask

   typedef struct {
      bit          is_wr;
      logic [16:0] addr;
      logic [7:0]  data;   // write data, or expected read data
   } op_t;

   op_t         ops [10];
   logic [7:0]  rd;
   int          lat, oe_n, cnt1, drv_n, we_n, done;
   int          reads, seen_we, resumed, got_ack, in_wh, acks, we_lows;
   logic        prev_oe;
   int          cnt_k [5];
   logic        full_k [5];
   logic        drop_k [5];

   initial begin
      ops[0] = '{1'b0, 17'h12345, 8'hA5};
      ops[1] = '{1'b1, 17'h0DE00, 8'h3C};
      ops[2] = '{1'b0, 17'h0DE00, 8'h3C};
      ops[3] = '{1'b1, 17'h1FFFF, 8'h81};
      ops[4] = '{1'b0, 17'h1FFFF, 8'h81};
      ops[5] = '{1'b0, 17'h00000, 8'h5A};
      ops[6] = '{1'b1, 17'h00000, 8'hFF};
      ops[7] = '{1'b0, 17'h00000, 8'hFF};
      ops[8] = '{1'b1, 17'h12345, 8'h00};
      ops[9] = '{1'b0, 17'h12345, 8'h00};

      rst      = 1'b1;
      vid_req  = 1'b0;
      vid_addr = '0;
      wr_push  = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      repeat (3) @(posedge clk100);
      #1;
      check("rst_s_ce", s_ce, 1);
      check("rst_s_oe", s_oe, 1);
      check("rst_s_we", s_we, 1);
      check("rst_s_drive", s_drive, 0);
      check("rst_o_saddr", o_saddr, 0);
      check("rst_s_dout", s_dout, 0);
      check("rst_vid_ack", vid_ack, 0);
      check("rst_vid_data", vid_data, 0);
      check("rst_wr_count", wr_count, 0);
      check("rst_wr_full", wr_full, 0);
      check("rst_wr_drop", wr_drop, 0);
      check("rst_busy", busy, 0);
      @(negedge clk100);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk100);
         if (ops[i].is_wr) begin
            do_write(ops[i].addr, ops[i].data, cnt1, drv_n, we_n, done);
            check($sformatf("op%0d_count_after_push", i), cnt1, 1);
            check($sformatf("op%0d_drive_cycles", i), drv_n, 7);
            check($sformatf("op%0d_we_low_cycles", i), we_n, 5);
            check($sformatf("op%0d_write_done", i), done, 1);
            check($sformatf("op%0d_mem", i), mem[ops[i].addr], ops[i].data);
         end else begin
            do_read(ops[i].addr, rd, lat, oe_n);
            check($sformatf("op%0d_latency", i), lat, 7);
            check($sformatf("op%0d_oe_low_cycles", i), oe_n, 6);
            check($sformatf("op%0d_data", i), rd, ops[i].data);
         end
      end

      // Continuous video traffic lets exactly STARVE reads overtake a queued write.
      @(negedge clk100);
      @(negedge clk100);
      vid_addr = 17'h00100;
      vid_req  = 1'b1;
      @(posedge clk100); #1;
      @(negedge clk100);
      wr_push = 1'b1;
      wr_addr = 17'h00200;
      wr_data = 8'h77;
      @(posedge clk100); #1;
      wr_push = 1'b0;
      reads   = 0;
      seen_we = 0;
      prev_oe = s_oe;
      for (int i = 0; i < 200 && seen_we == 0; i++) begin
         @(posedge clk100); #1;
         if (!s_we) seen_we = 1;
         else if (prev_oe && !s_oe) reads++;
         prev_oe = s_oe;
      end
      check("t3_reads_before_write", reads, 4);
      check("t3_write_started", seen_we, 1);
      resumed = 0;
      for (int i = 0; i < 40 && resumed == 0; i++) begin
         @(posedge clk100); #1;
         if (!s_oe) resumed = 1;
      end
      check("t3_reads_resume", resumed, 1);
      check("t3_mem_written", mem[17'h00200], 8'h77);
      got_ack = 0;
      for (int i = 0; i < 40 && got_ack == 0; i++) begin
         @(posedge clk100); #1;
         if (vid_ack) got_ack = 1;
      end
      vid_req = 1'b0;
      check("t3_final_ack", got_ack, 1);
      wait_idle("t3_idle", 40);

      // FIFO fills during a read; fifth push is dropped; push on a pop edge is taken.
      @(negedge clk100);
      vid_addr = 17'h1FFFF;
      vid_req  = 1'b1;
      @(posedge clk100); #1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk100);
         wr_push = 1'b1;
         wr_addr = (k == 4) ? 17'h00500 : 17'h00400 + 17'(k);
         wr_data = (k == 4) ? 8'hEE : 8'h10 + 8'(k);
         @(posedge clk100); #1;
         cnt_k[k]  = int'(wr_count);
         full_k[k] = wr_full;
         drop_k[k] = wr_drop;
      end
      wr_push = 1'b0;
      check("t4_count1", cnt_k[0], 1);
      check("t4_count2", cnt_k[1], 2);
      check("t4_count3", cnt_k[2], 3);
      check("t4_count4", cnt_k[3], 4);
      check("t4_count5", cnt_k[4], 4);
      check("t4_full_at3", full_k[2], 0);
      check("t4_full_at4", full_k[3], 1);
      check("t4_drop_at4", drop_k[3], 0);
      check("t4_drop_at5", drop_k[4], 1);
      @(posedge clk100); #1;
      check("t4_drop_one_cycle", wr_drop, 0);
      got_ack = vid_ack ? 1 : 0;
      for (int i = 0; i < 20 && got_ack == 0; i++) begin
         @(posedge clk100); #1;
         if (vid_ack) got_ack = 1;
      end
      vid_req = 1'b0;
      check("t4_read_ack", got_ack, 1);
      check("t4_read_data", vid_data, 8'h81);
      in_wh = 0;
      for (int i = 0; i < 40 && in_wh == 0; i++) begin
         @(posedge clk100); #1;
         if (s_drive && s_ce && s_we) in_wh = 1;
      end
      check("t4_reached_wh", in_wh, 1);
      @(negedge clk100);
      wr_push = 1'b1;
      wr_addr = 17'h00300;
      wr_data = 8'h99;
      @(posedge clk100); #1;
      wr_push = 1'b0;
      check("t4_pushpop_count", wr_count, 4);
      check("t4_pushpop_full", wr_full, 1);
      check("t4_pushpop_drop", wr_drop, 0);
      wait_idle("t4_drain", 100);
      check("t4_mem_first", mem[17'h00400], 8'h10);
      check("t4_mem_fourth", mem[17'h00403], 8'h13);
      check("t4_mem_pushpop", mem[17'h00300], 8'h99);
      check("t4_mem_dropped", mem[17'h00500], 8'h00);

      // Reset in the third WE-low cycle kills the write and the queued one.
      @(negedge clk100);
      wr_push = 1'b1;
      wr_addr = 17'h00600;
      wr_data = 8'h42;
      @(negedge clk100);
      wr_addr = 17'h00601;
      wr_data = 8'h43;
      @(posedge clk100); #1;
      wr_push = 1'b0;
      seen_we = 0;
      for (int i = 0; i < 20 && seen_we == 0; i++) begin
         @(posedge clk100); #1;
         if (!s_we) seen_we = 1;
      end
      check("t5_we_low_seen", seen_we, 1);
      repeat (2) @(posedge clk100);
      #1;
      check("t5_in_wp3", s_we, 0);
      @(negedge clk100);
      rst = 1'b1;
      @(posedge clk100); #1;
      check("t5_rst_s_we", s_we, 1);
      check("t5_rst_s_ce", s_ce, 1);
      check("t5_rst_s_drive", s_drive, 0);
      check("t5_rst_count", wr_count, 0);
      check("t5_rst_busy", busy, 0);
      @(negedge clk100);
      rst     = 1'b0;
      we_lows = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk100); #1;
         if (!s_we) we_lows++;
      end
      check("t5_queued_write_lost", we_lows, 0);

      // Reset during a read: no ack, read data register cleared.
      @(negedge clk100);
      vid_addr = 17'h0DE00;
      vid_req  = 1'b1;
      repeat (3) @(posedge clk100);
      @(negedge clk100);
      rst     = 1'b1;
      vid_req = 1'b0;
      @(posedge clk100); #1;
      check("t5_rd_rst_s_oe", s_oe, 1);
      check("t5_rd_rst_s_ce", s_ce, 1);
      check("t5_rd_rst_vid_data", vid_data, 0);
      @(negedge clk100);
      rst  = 1'b0;
      acks = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk100); #1;
         if (vid_ack) acks++;
      end
      check("t5_no_ack", acks, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
